id_ex_stage: RTL and testbench

//  ID/EX pipeline register plus EX-stage operand forwarding and load-use hazard detection.

---
 rtl/id_ex_stage.sv | 173 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use hazard detection.
// Drives the ALU operands, op code and the downstream control bits.
module id_ex_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR      = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     id_valid,
    input  logic [DATA_WIDTH-1:0]    id_rd1,
    input  logic [DATA_WIDTH-1:0]    id_rd2,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [REG_ADDR-1:0]      id_rs1,
    input  logic [REG_ADDR-1:0]      id_rs2,
    input  logic [REG_ADDR-1:0]      id_rd,
    input  logic                     id_alusrc,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_regwrite,
    input  logic                     id_memread,
    input  logic                     id_memwrite,
    input  logic                     id_memtoreg,
    input  logic                     exmem_regwrite,
    input  logic [REG_ADDR-1:0]      exmem_rd,
    input  logic [DATA_WIDTH-1:0]    exmem_result,
    input  logic                     memwb_regwrite,
    input  logic [REG_ADDR-1:0]      memwb_rd,
    input  logic [DATA_WIDTH-1:0]    memwb_result,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     ex_valid,
    output logic [REG_ADDR-1:0]      ex_rd,
    output logic                     ex_regwrite,
    output logic                     ex_memread,
    output logic                     ex_memwrite,
    output logic                     ex_memtoreg,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic                     load_use_hazard
);

    logic                     valid_reg,    valid_next;
    logic [DATA_WIDTH-1:0]    rd1_reg,      rd1_next;
    logic [DATA_WIDTH-1:0]    rd2_reg,      rd2_next;
    logic [DATA_WIDTH-1:0]    imm_reg,      imm_next;
    logic [REG_ADDR-1:0]      rs1_reg,      rs1_next;
    logic [REG_ADDR-1:0]      rs2_reg,      rs2_next;
    logic [REG_ADDR-1:0]      rd_reg,       rd_next;
    logic                     alusrc_reg,   alusrc_next;
    logic [OPCODE_LENGTH-1:0] op_reg,       op_next;
    logic                     regwrite_reg, regwrite_next;
    logic                     memread_reg,  memread_next;
    logic                     memwrite_reg, memwrite_next;
    logic                     memtoreg_reg, memtoreg_next;

    logic bubble;

    // A load in EX whose destination is read by the ID instruction; a flush makes it moot.
    assign load_use_hazard = valid_reg & memread_reg & (rd_reg != '0) & id_valid
                           & ((rd_reg == id_rs1) | (rd_reg == id_rs2)) & ~flush;

    assign bubble = flush | (~stall & load_use_hazard);

    always_comb begin
        valid_next    = valid_reg;
        rd1_next      = rd1_reg;
        rd2_next      = rd2_reg;
        imm_next      = imm_reg;
        rs1_next      = rs1_reg;
        rs2_next      = rs2_reg;
        rd_next       = rd_reg;
        alusrc_next   = alusrc_reg;
        op_next       = op_reg;
        regwrite_next = regwrite_reg;
        memread_next  = memread_reg;
        memwrite_next = memwrite_reg;
        memtoreg_next = memtoreg_reg;
        if (bubble) begin
            // Bubble only kills control and destination; operand data is left as-is.
            valid_next    = 1'b0;
            rd_next       = '0;
            op_next       = '0;
            regwrite_next = 1'b0;
            memread_next  = 1'b0;
            memwrite_next = 1'b0;
            memtoreg_next = 1'b0;
        end else if (!stall) begin
            valid_next    = id_valid;
            rd1_next      = id_rd1;
            rd2_next      = id_rd2;
            imm_next      = id_imm;
            rs1_next      = id_rs1;
            rs2_next      = id_rs2;
            rd_next       = id_rd;
            alusrc_next   = id_alusrc;
            op_next       = id_alu_op;
            regwrite_next = id_regwrite;
            memread_next  = id_memread;
            memwrite_next = id_memwrite;
            memtoreg_next = id_memtoreg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg    <= 1'b0;
            rd1_reg      <= '0;
            rd2_reg      <= '0;
            imm_reg      <= '0;
            rs1_reg      <= '0;
            rs2_reg      <= '0;
            rd_reg       <= '0;
            alusrc_reg   <= 1'b0;
            op_reg       <= '0;
            regwrite_reg <= 1'b0;
            memread_reg  <= 1'b0;
            memwrite_reg <= 1'b0;
            memtoreg_reg <= 1'b0;
        end else begin
            valid_reg    <= valid_next;
            rd1_reg      <= rd1_next;
            rd2_reg      <= rd2_next;
            imm_reg      <= imm_next;
            rs1_reg      <= rs1_next;
            rs2_reg      <= rs2_next;
            rd_reg       <= rd_next;
            alusrc_reg   <= alusrc_next;
            op_reg       <= op_next;
            regwrite_reg <= regwrite_next;
            memread_reg  <= memread_next;
            memwrite_reg <= memwrite_next;
            memtoreg_reg <= memtoreg_next;
        end
    end

    // Operand 0 is rs1 (SrcA), operand 1 is rs2 (SrcB / store data).
    logic [1:0][REG_ADDR-1:0]   src_idx;
    logic [1:0][DATA_WIDTH-1:0] src_val;
    logic [1:0][DATA_WIDTH-1:0] fwd_val;

    assign src_idx[0] = rs1_reg;
    assign src_idx[1] = rs2_reg;
    assign src_val[0] = rd1_reg;
    assign src_val[1] = rd2_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd_val[gi] = src_val[gi];
                if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src_idx[gi]))
                    fwd_val[gi] = exmem_result;
                else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src_idx[gi]))
                    fwd_val[gi] = memwb_result;
            end
        end
    endgenerate

    assign SrcA          = fwd_val[0];
    assign SrcB          = alusrc_reg ? imm_reg : fwd_val[1];
    assign ex_store_data = fwd_val[1];

    assign Operation   = op_reg;
    assign ex_valid    = valid_reg;
    assign ex_rd       = rd_reg;
    assign ex_regwrite = regwrite_reg;
    assign ex_memread  = memread_reg;
    assign ex_memwrite = memwrite_reg;
    assign ex_memtoreg = memtoreg_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: slot-level reference model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
    logic [31:0] id_rd1 = '0, id_rd2 = '0, id_imm = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_alusrc = 1'b0;
    logic [3:0]  id_alu_op = '0;
    logic        id_regwrite = 1'b0, id_memread = 1'b0, id_memwrite = 1'b0, id_memtoreg = 1'b0;
    logic        exmem_regwrite = 1'b0, memwb_regwrite = 1'b0;
    logic [4:0]  exmem_rd = '0, memwb_rd = '0;
    logic [31:0] exmem_result = '0, memwb_result = '0;
    logic [31:0] SrcA, SrcB, ex_store_data;
    logic [3:0]  Operation;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, load_use_hazard;
    logic [4:0]  ex_rd;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #10 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alusrc(id_alusrc), .id_alu_op(id_alu_op),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_store_data(ex_store_data), .load_use_hazard(load_use_hazard)
    );

    // What the EX slot is supposed to hold: the instruction last accepted, or a bubble.
    typedef struct packed {
        logic        valid;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        alusrc;
        logic [3:0]  op;
        logic        regwrite, memread, memwrite, memtoreg;
    } slot_t;

    slot_t m = '0;

    function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
        if (exmem_regwrite && exmem_rd != 0 && exmem_rd == rs) return exmem_result;
        if (memwb_regwrite && memwb_rd != 0 && memwb_rd == rs) return memwb_result;
        return rf;
    endfunction

    function automatic logic model_hazard();
        return m.valid && m.memread && m.rd != 0 && id_valid && !flush
               && (m.rd == id_rs1 || m.rd == id_rs2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        slot_t t;
        t = m;
        if (!rst_n) begin
            t = '0;
        end else if (flush || (!stall && model_hazard())) begin
            t.valid = 0; t.rd = 0; t.op = 0;
            t.regwrite = 0; t.memread = 0; t.memwrite = 0; t.memtoreg = 0;
        end else if (!stall) begin
            t = '{id_valid, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_alusrc,
                  id_alu_op, id_regwrite, id_memread, id_memwrite, id_memtoreg};
        end
        m <= t;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("SrcA", SrcA, operand(m.rs1, m.rd1));
            check("SrcB", SrcB, m.alusrc ? m.imm : operand(m.rs2, m.rd2));
            check("ex_store_data", ex_store_data, operand(m.rs2, m.rd2));
            check("Operation", {28'd0, Operation}, {28'd0, m.op});
            check("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
            check("ex_rd", {27'd0, ex_rd}, {27'd0, m.rd});
            check("ex_ctrl", {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg},
                  {28'd0, m.regwrite, m.memread, m.memwrite, m.memtoreg});
            check("load_use_hazard", {31'd0, load_use_hazard}, {31'd0, model_hazard()});
            $display("cycle t=%0t valid=%0b rd=%0d op=%h SrcA=%h SrcB=%h store=%h haz=%0b",
                     $time, ex_valid, ex_rd, Operation, SrcA, SrcB, ex_store_data, load_use_hazard);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic at_check();
        @(negedge clk);
        #1;
    endtask

    task automatic id_load(input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [4:0] d, input logic [3:0] op,
                           input logic rw, input logic mr);
        id_valid = 1; id_rd1 = r1; id_rd2 = r2; id_rs1 = s1; id_rs2 = s2; id_rd = d;
        id_alu_op = op; id_regwrite = rw; id_memread = mr; id_memtoreg = mr;
        id_memwrite = 0; id_alusrc = 0; id_imm = 0;
    endtask

    initial begin
        // reset state
        cyc();
        chk_en = 1'b1;
        cyc();
        at_check();
        check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_SrcA", SrcA, 32'd0);
        rst_n = 1'b1;

        // pass-through add
        cyc();
        id_load(32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 4'b0010, 1'b1, 1'b0);
        cyc();
        at_check();
        check("t2_SrcA", SrcA, 32'd5);
        check("t2_SrcB", SrcB, 32'd7);
        check("t2_Op", {28'd0, Operation}, 32'h2);
        // reset dropped between edges clears everything at once
        #1 rst_n = 1'b0;
        #1;
        check("t1_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("t1_SrcA", SrcA, 32'd0);
        check("t1_Op", {28'd0, Operation}, 32'd0);
        cyc();
        rst_n = 1'b1;

        // forward priority
        id_load(32'h11, 32'h22, 5'd3, 5'd4, 5'd9, 4'b0000, 1'b1, 1'b0);
        cyc();
        stall = 1; id_valid = 0;
        exmem_regwrite = 1; exmem_rd = 3; exmem_result = 32'hAA;
        memwb_regwrite = 1; memwb_rd = 3; memwb_result = 32'hBB;
        at_check();
        check("t3_exmem", SrcA, 32'hAA);
        #1 exmem_regwrite = 0;
        #1 check("t3_memwb", SrcA, 32'hBB);
        #1 exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0;
        #1 check("t3_rd0", SrcA, 32'h11);
        cyc();
        stall = 0; exmem_regwrite = 0; memwb_regwrite = 0;

        // load-use
        id_load(32'h0, 32'h0, 5'd1, 5'd0, 5'd5, 4'b0000, 1'b1, 1'b1);
        cyc();
        id_load(32'h30, 32'h40, 5'd5, 5'd6, 5'd7, 4'b0010, 1'b1, 1'b0);
        at_check();
        check("t4_hazard", {31'd0, load_use_hazard}, 32'd1);
        cyc();
        at_check();
        check("t4_bubble_valid", {31'd0, ex_valid}, 32'd0);
        check("t4_bubble_memread", {31'd0, ex_memread}, 32'd0);
        check("t4_hazard_drop", {31'd0, load_use_hazard}, 32'd0);
        cyc();
        at_check();
        check("t4_add_rd", {27'd0, ex_rd}, 32'd7);
        check("t4_add_valid", {31'd0, ex_valid}, 32'd1);

        // stall / flush
        stall = 1; id_rd = 5'd12; id_alu_op = 4'b0110;
        cyc();
        cyc();
        at_check();
        check("t5_stall_rd", {27'd0, ex_rd}, 32'd7);
        check("t5_stall_op", {28'd0, Operation}, 32'h2);
        flush = 1;
        cyc();
        at_check();
        check("t5_flush_valid", {31'd0, ex_valid}, 32'd0);
        check("t5_flush_rd", {27'd0, ex_rd}, 32'd0);
        stall = 0; flush = 0;
        id_load(32'h0, 32'h0, 5'd1, 5'd0, 5'd5, 4'b0000, 1'b1, 1'b1);
        cyc();
        id_load(32'h1, 32'h2, 5'd8, 5'd5, 5'd9, 4'b0010, 1'b1, 1'b0);
        flush = 1;
        at_check();
        check("t5_flush_hazard", {31'd0, load_use_hazard}, 32'd0);
        cyc();
        flush = 0;

        // immediate operand with forwarded store data
        id_load(32'h0, 32'h99, 5'd0, 5'd4, 5'd2, 4'b0000, 1'b1, 1'b0);
        id_alusrc = 1; id_imm = 32'hFFFF_FFFC; id_memwrite = 1;
        cyc();
        exmem_regwrite = 1; exmem_rd = 4; exmem_result = 32'h12;
        at_check();
        check("t6_SrcB", SrcB, 32'hFFFF_FFFC);
        check("t6_store", ex_store_data, 32'h12);

        // mixed traffic against the model
        for (int i = 0; i < 24; i++) begin
            cyc();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 6) == 0);
            id_valid = $urandom_range(0, 1);
            id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
            id_rs1 = 5'($urandom_range(0, 5)); id_rs2 = 5'($urandom_range(0, 5));
            id_rd = 5'($urandom_range(0, 5));
            id_alusrc = $urandom_range(0, 1); id_alu_op = 4'($urandom);
            id_regwrite = $urandom_range(0, 1); id_memread = $urandom_range(0, 1);
            id_memwrite = $urandom_range(0, 1); id_memtoreg = $urandom_range(0, 1);
            exmem_regwrite = $urandom_range(0, 1); exmem_rd = 5'($urandom_range(0, 5));
            exmem_result = $urandom;
            memwb_regwrite = $urandom_range(0, 1); memwb_rd = 5'($urandom_range(0, 5));
            memwb_result = $urandom;
        end
        cyc();
        at_check();
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
